// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
// start/done handshake; result is bin mod 10^DIGITS with an overflow flag.
module bin_to_bcd_seq #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int CAT_W = ACC_W + IN_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state;
    logic [IN_W-1:0]    sh;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic [ACC_W-1:0]   adj;
    logic [CAT_W-1:0]   shifted;
    logic [ACC_W-1:0]   acc_next;
    logic [IN_W-1:0]    sh_next;
    logic               carry_out;
    logic               last_iter;

    // Digits are adjusted independently; a carry never crosses a digit boundary.
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // The top bit of the shifted word is whatever fell off the digit register.
    always_comb begin
        shifted   = {adj, sh, 1'b0};
        carry_out = shifted[CAT_W-1];
        acc_next  = shifted[CAT_W-2 -: ACC_W];
        sh_next   = shifted[IN_W-1:0];
        last_iter = (cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh    <= bin;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    sh  <= sh_next;
                    acc <= acc_next;
                    ovf <= ovf | carry_out;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bcd      <= acc_next;
                        overflow <= ovf | carry_out;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done <= 1'b0;
                    // A start seen here chains straight into the next conversion.
                    if (start) begin
                        sh    <= bin;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance
// share stimulus and are compared against a decimal arithmetic model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy, done, overflow;
    logic [11:0] bcd;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    bin_to_bcd_seq #(.IN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digits by plain division.
    function automatic logic [11:0] ref_bcd3(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] ref_bcd2(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic kick(input logic [7:0] v);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the sample index (negedges after accept) at which done was seen, 0 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bin = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (bcd !== 12'h000) begin bad++; $display("[TB] FAIL reset_bcd got=%h want=000", bcd); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", overflow); end
    endtask

    task automatic test_latency;
        int seen;
        seen = 0;
        kick(8'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            total++;
            if (busy !== (k <= 8)) begin
                bad++; $display("[TB] FAIL latency_busy cycle=%0d got=%b want=%b", k, busy, (k <= 8));
            end
            total++;
            if (done !== (k == 9)) begin
                bad++; $display("[TB] FAIL latency_done cycle=%0d got=%b want=%b", k, done, (k == 9));
            end
            if (done) seen = k;
        end
        total++; if (bcd !== 12'h000) begin bad++; $display("[TB] FAIL latency_bcd got=%h want=000", bcd); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL latency_ovf got=%b want=0", overflow); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL latency_pulse got=%b want=0 seen=%0d", done, seen); end
    endtask

    task automatic test_sweep;
        int vals[$];
        int n;
        vals = '{0, 1, 9, 10, 99, 100, 101, 199, 200, 254, 255};
        repeat (30) vals.push_back(int'($urandom_range(0, 255)));
        foreach (vals[i]) begin
            kick(8'(vals[i]));
            wait_done(n);
            total++;
            if (n != 9) begin bad++; $display("[TB] FAIL sweep_lat v=%0d got=%0d want=9", vals[i], n); end
            total++;
            if (bcd !== ref_bcd3(vals[i])) begin
                bad++; $display("[TB] FAIL sweep_bcd3 v=%0d got=%h want=%h", vals[i], bcd, ref_bcd3(vals[i]));
            end
            total++;
            if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL sweep_ovf3 v=%0d got=%b want=0", vals[i], overflow); end
            total++;
            if (bcd2 !== ref_bcd2(vals[i]) || overflow2 !== (vals[i] >= 100)) begin
                bad++; $display("[TB] FAIL sweep_d2 v=%0d got=%h/%b want=%h/%b",
                                vals[i], bcd2, overflow2, ref_bcd2(vals[i]), (vals[i] >= 100));
            end
            for (int d = 0; d < 3; d++) begin
                total++;
                if (bcd[4*d +: 4] > 4'd9) begin
                    bad++; $display("[TB] FAIL sweep_digit v=%0d digit=%0d got=%h want<=9", vals[i], d, bcd[4*d +: 4]);
                end
            end
        end
    endtask

    task automatic test_ignore_start;
        int n;
        kick(8'd200);
        repeat (3) @(negedge clk);
        bin   = 8'd17;
        start = 1'b1;
        wait_done(n);
        total++; if (n + 3 != 9) begin bad++; $display("[TB] FAIL ignore_lat got=%0d want=9", n + 3); end
        total++; if (bcd !== 12'h200) begin bad++; $display("[TB] FAIL ignore_bcd got=%h want=200", bcd); end
        // start still high through the DONE cycle: chained conversion of 17
        wait_done(n);
        start = 1'b0;
        total++; if (n != 9) begin bad++; $display("[TB] FAIL chain_lat got=%0d want=9", n); end
        total++; if (bcd !== 12'h017) begin bad++; $display("[TB] FAIL chain_bcd got=%h want=017", bcd); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL chain_idle got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        int vals[6];
        int n;
        foreach (vals[i]) vals[i] = int'($urandom_range(0, 255));
        @(negedge clk);
        bin   = 8'(vals[0]);
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_done(n);
            total++;
            if (n != 9 || bcd !== ref_bcd3(vals[i])) begin
                bad++; $display("[TB] FAIL b2b i=%0d v=%0d got=%h lat=%0d want=%h lat=9", i, vals[i], bcd, n, ref_bcd3(vals[i]));
            end
            if (i < 5) bin = 8'(vals[i+1]);
            else start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        logic saw_done;
        kick(8'd123);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        total++; if (bcd !== 12'h000) begin bad++; $display("[TB] FAIL midrst_bcd got=%h want=000", bcd); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ovf got=%b want=0", overflow); end
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_nodone got=%b want=0", saw_done); end
        kick(8'd45);
        wait_done(n);
        total++;
        if (n != 9 || bcd !== 12'h045) begin
            bad++; $display("[TB] FAIL midrst_after got=%h lat=%0d want=045 lat=9", bcd, n);
        end
    endtask

    task automatic test_hold;
        int n;
        kick(8'd255);
        wait_done(n);
        total++; if (n != 9 || bcd !== 12'h255) begin bad++; $display("[TB] FAIL hold_init got=%h lat=%0d want=255 lat=9", bcd, n); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bin = 8'($urandom);
            total++;
            if (bcd !== 12'h255 || overflow !== 1'b0 || done !== 1'b0 || overflow2 !== 1'b1 || bcd2 !== 8'h55) begin
                bad++; $display("[TB] FAIL hold k=%0d got=%h/%b/%b d2=%h/%b want=255/0/0 d2=55/1",
                                k, bcd, overflow, done, bcd2, overflow2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
